uart_tx_frame: RTL and testbench

//  UART transmitter: serialises one parallel word per Data_Valid strobe into a frame:

---
 rtl/uart_tx_frame.sv | 131 +++++++++++++
 tb/tb_uart_tx_frame.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
//   UART transmitter. Serialises one parallel word per accepted Data_Valid
//   into a frame: start bit (0), DATA_WIDTH data bits LSB first, an optional
//   parity bit, then one stop bit (1). One bit per clk_TX cycle.
//
// Ports
//   clk_TX      in   TX bit clock, rising-edge
//   rst         in   asynchronous active-high reset
//   P_DATA      in   parallel word, captured on acceptance
//   Data_Valid  in   send request, accepted only while idle
//   PAR_EN      in   1 = append parity bit, captured on acceptance
//   PAR_TYP     in   0 = even, 1 = odd parity, captured on acceptance
//   TX_OUT      out  serial line, registered, idles high
//   busy        out  high while a frame (start..stop) is on the line
// ---------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_TX,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_reg,   state_next;
    logic [CNT_W-1:0]        cnt_reg,     cnt_next;
    logic [DATA_WIDTH-1:0]   shift_reg,   shift_next;
    logic                    par_en_reg,  par_en_next;
    logic                    par_bit_reg, par_bit_next;
    logic                    tx_reg,      tx_next;
    logic                    busy_reg,    busy_next;

    always_ff @(posedge clk_TX or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            shift_reg   <= '0;
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            shift_reg   <= shift_next;
            par_en_reg  <= par_en_next;
            par_bit_reg <= par_bit_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
        end
    end

    // The line value is computed for the state being entered, so TX_OUT and
    // busy are both plain flops that change together on the same edge.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        shift_next   = shift_reg;
        par_en_next  = par_en_reg;
        par_bit_next = par_bit_reg;
        tx_next      = tx_reg;

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (Data_Valid) begin
                    state_next   = START;
                    shift_next   = P_DATA;
                    par_en_next  = PAR_EN;
                    // Even parity bit = XOR of data; odd parity inverts it.
                    par_bit_next = (^P_DATA) ^ PAR_TYP;
                    tx_next      = 1'b0;
                end
            end
            START: begin
                state_next = DATA;
                cnt_next   = '0;
                tx_next    = shift_reg[0];
            end
            DATA: begin
                if (cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
                    if (par_en_reg) begin
                        state_next = PARITY;
                        tx_next    = par_bit_reg;
                    end else begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end
                end else begin
                    // Shift right so the next data bit is always at index 0.
                    cnt_next   = cnt_reg + CNT_W'(1);
                    shift_next = shift_reg >> 1;
                    tx_next    = shift_next[0];
                end
            end
            PARITY: begin
                state_next = STOP;
                tx_next    = 1'b1;
            end
            STOP: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign TX_OUT = tx_reg;
    assign busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
//   Self-checking bench for uart_tx_frame. A queue-based frame model predicts
//   the line and busy flag each cycle; directed cases are followed by a
//   randomized stimulus phase.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

    localparam int W = 8;

    logic         clk_TX = 1'b0;
    logic         rst;
    logic [W-1:0] P_DATA;
    logic         Data_Valid;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic         TX_OUT;
    logic         busy;

    int vectors_applied = 0;
    int miscompares     = 0;

    // Reference model state: bits still to appear after the current one.
    logic q[$];
    logic exp_tx   = 1'b1;
    logic exp_busy = 1'b0;
    int   last_len = 0;
    int   busy_run = 0;

    uart_tx_frame #(.DATA_WIDTH(W)) dut (
        .clk_TX     (clk_TX),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 clk_TX = ~clk_TX;

    task automatic check_val(input string tag, input int got, input int exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // One rising edge of the model: a frame is a list of bits; an accepted
    // request builds it, each edge shows the next bit, and once the stop bit
    // has been shown the line drops back to idle for at least one cycle.
    task automatic model_edge(input logic dv, input logic [W-1:0] d,
                              input logic pe, input logic pt);
        if (exp_busy) begin
            if (q.size() > 0) begin
                exp_tx = q.pop_front();
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
            end
        end else if (dv) begin
            q.delete();
            q.push_back(1'b0);
            for (int i = 0; i < W; i++) q.push_back(d[i]);
            if (pe) q.push_back((^d) ^ pt);
            q.push_back(1'b1);
            last_len = q.size();
            exp_tx   = q.pop_front();
            exp_busy = 1'b1;
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, check at the next
    // falling edge. Also measures each busy run against the frame length.
    task automatic step(input logic dv, input logic [W-1:0] d,
                        input logic pe, input logic pt);
        Data_Valid = dv;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        @(posedge clk_TX);
        model_edge(dv, d, pe, pt);
        @(negedge clk_TX);
        check_val("tx", int'(TX_OUT), int'(exp_tx));
        check_val("busy", int'(busy), int'(exp_busy));
        if (busy === 1'b1) begin
            busy_run++;
        end else begin
            if (busy_run > 0) check_val("frame_len", busy_run, last_len);
            busy_run = 0;
        end
        $display("cyc t=%0t dv=%0b d=%02h pe=%0b pt=%0b -> tx=%0b busy=%0b",
                 $time, dv, d, pe, pt, TX_OUT, busy);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] rd;
        rst        = 1'b1;
        Data_Valid = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        @(negedge clk_TX);
        @(negedge clk_TX);
        check_val("reset_tx", int'(TX_OUT), 1);
        check_val("reset_busy", int'(busy), 0);
        rst = 1'b0;
        idle_steps(2);

        // Plain 8N1 frame of 0xA5.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        idle_steps(12);

        // Even and odd parity on 0xA5.
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        idle_steps(13);
        step(1'b1, 8'hA5, 1'b1, 1'b1);
        idle_steps(13);

        // All-zero payload, odd parity.
        step(1'b1, 8'h00, 1'b1, 1'b1);
        idle_steps(13);

        // Requests while busy are ignored; inputs changing mid-frame too.
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'hFF, 1'b1, 1'b1);
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        step(1'b0, 8'hFF, 1'b1, 1'b1);
        step(1'b1, 8'hFF, 1'b0, 1'b1);
        idle_steps(12);

        // Held request: back-to-back frames with one idle cycle between.
        for (int i = 0; i < 35; i++) step(1'b1, 8'h55, 1'b0, 1'b0);
        idle_steps(12);

        // Asynchronous reset in the middle of the data bits of 0x3C.
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        idle_steps(4);
        rst = 1'b1;
        #1;
        check_val("async_rst_tx", int'(TX_OUT), 1);
        check_val("async_rst_busy", int'(busy), 0);
        q.delete();
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
        busy_run = 0;
        @(negedge clk_TX);
        idle_steps(2);
        rst = 1'b0;
        idle_steps(12);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rd = W'($urandom);
            step(($urandom_range(0, 3) == 0), rd,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle_steps(14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
